// File: rtl/meter_pkg.sv
// Shared definitions for the parking-meter blocks: interval-timer state
// encoding, default timing constants and a counter-width helper.
package meter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DEF_PRESCALE     = 100000000;
    localparam int DEF_SEG_SECONDS  = 1800;
    localparam int DEF_WARN_SECONDS = 300;
    localparam int DEF_BLINK_DIV    = 50000000;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int width_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: one-cycle tick every DIV enabled cycles. The count
// freezes while disabled and restarts from zero on clear.
module tick_prescaler
    import meter_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam int            CW   = width_of(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == LAST);
    assign o_tick = i_en && !i_clr && w_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_last ? '0 : r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/meter_interval_timer.sv
// Interval timer for the parking meter: a ct pulse loads one paid interval,
// which counts down in seconds and pulses t for one cycle on expiry.
module meter_interval_timer
    import meter_pkg::*;
#(
    parameter int PRESCALE     = DEF_PRESCALE,
    parameter int SEG_SECONDS  = DEF_SEG_SECONDS,
    parameter int WARN_SECONDS = DEF_WARN_SECONDS,
    parameter int BLINK_DIV    = DEF_BLINK_DIV,
    parameter int REM_W        = width_of(SEG_SECONDS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ct,
    input  logic             hold,
    output logic             t,
    output logic             busy,
    output logic [REM_W-1:0] remaining,
    output logic             warn,
    output logic             blink,
    output logic             expired
);

    localparam logic [REM_W-1:0] SEG_LOAD = REM_W'(SEG_SECONDS);
    localparam logic [31:0]      WARN_LIM = 32'(WARN_SECONDS);

    state_t           r_state;
    logic [REM_W-1:0] r_rem;
    logic             r_expired;
    logic             r_blink;

    logic w_busy;
    logic w_warn;
    logic w_sec_en;
    logic w_tick;
    logic w_blink_tick;

    assign w_busy   = (r_state == RUN) || (r_state == HOLD);
    assign w_warn   = w_busy && (r_rem != '0) && (32'(r_rem) <= WARN_LIM);
    // HOLD with hold released counts like RUN, so the frozen phase resumes at once.
    assign w_sec_en = w_busy && !hold;

    tick_prescaler #(.DIV(PRESCALE)) u_sec_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (w_sec_en),
        .i_clr  (ct),
        .o_tick (w_tick)
    );

    tick_prescaler #(.DIV(BLINK_DIV)) u_blink_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (w_warn),
        .i_clr  (!w_warn),
        .o_tick (w_blink_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_rem     <= '0;
            r_expired <= 1'b0;
        end else if (ct) begin
            r_state   <= hold ? HOLD : RUN;
            r_rem     <= SEG_LOAD;
            r_expired <= 1'b0;
        end else begin
            case (r_state)
                IDLE: r_state <= IDLE;
                RUN, HOLD: begin
                    if (hold) begin
                        r_state <= HOLD;
                    end else begin
                        r_state <= RUN;
                        if (w_tick && r_rem != '0) begin
                            r_rem <= r_rem - REM_W'(1);
                            if (r_rem == REM_W'(1)) r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    r_state   <= IDLE;
                    r_expired <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink <= 1'b0;
        end else if (!w_warn) begin
            r_blink <= 1'b0;
        end else if (w_blink_tick) begin
            r_blink <= !r_blink;
        end
    end

    assign t         = (r_state == DONE);
    assign busy      = w_busy;
    assign remaining = r_rem;
    assign warn      = w_warn;
    // Gated so the flasher drops in the same cycle warn does.
    assign blink     = r_blink && w_warn;
    assign expired   = r_expired;

endmodule

// File: doc/meter_interval_timer.md
Name: meter_interval_timer

Overview:
- Interval timer controller for the parking-meter FSM.
- Accepts the FSM's one-cycle count-trigger `ct` and times one paid interval, 30 min by default.
- Pulses `t` back to the FSM when the interval expires.
- Drives remaining-time, low-time warning, blink and expired indicators for the meter display.

Parameters:
- PRESCALE, 100000000, clk cycles per one-second tick (≥2)
- SEG_SECONDS, 1800, seconds loaded per `ct` (≥1)
- WARN_SECONDS, 300, `warn` asserted when remaining ≤ this and nonzero
- BLINK_DIV, 50000000, clk cycles per `blink` half-period (≥1)
- REM_W, $clog2(SEG_SECONDS+1), width of `remaining` (derived; not overridden)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ct  in  1  load/start pulse from meter FSM
- hold  in  1  pause countdown (free period); level
- t  out  1  interval-done pulse to meter FSM, exactly one cycle
- busy  out  1  high in RUN or HOLD
- remaining  out  REM_W  seconds left in current interval
- warn  out  1  low-time indicator
- blink  out  1  warning flasher
- expired  out  1  sticky "time expired" indicator

Behaviour:
- One clock; reset is asynchronous and active-low.
- rst_n low, at any time including mid-count:
  - state=IDLE; prescaler, remaining, blink counter and `blink` = 0; `expired`=0.
  - All outputs 0 while rst_n is low.
- States: IDLE, RUN, HOLD, DONE. Registered state; outputs decoded from registers only, so no combinational path from inputs.
- Precedence each edge: reset > `ct` > `hold` > tick.
- IDLE:
  - ct=1 → RUN if hold=0, else HOLD.
  - On load: remaining←SEG_SECONDS, prescaler←0.
- RUN:
  - Prescaler increments each cycle.
  - At PRESCALE-1: prescaler←0, remaining←remaining-1.
  - If that decrement takes remaining from 1 to 0, next state = DONE.
  - hold=1 → HOLD; prescaler and remaining frozen, not cleared.
- HOLD:
  - hold=0 → RUN; prescaler resumes from its frozen value.
  - ct=1 → reload (remaining←SEG_SECONDS, prescaler←0) and stay in HOLD while hold=1.
- ct in RUN (retrigger): reload; state RUN (or HOLD if hold=1). A ct coinciding with a tick: reload wins and the decrement is dropped.
- DONE:
  - Lasts exactly one cycle; t=1 only in DONE.
  - Next state IDLE, or RUN/HOLD with reload if ct=1 in that cycle.
  - On leaving DONE: expired←1.
- Latency: ct sampled at edge k → busy=1 and remaining=SEG_SECONDS from cycle k+1. Expiry t at cycle k+1+SEG_SECONDS·PRESCALE.
- remaining:
  - Never wraps; no decrement in IDLE/DONE.
  - Holds 0 in DONE and IDLE after expiry.
- expired: set on exit from DONE; cleared by ct or reset.
- warn = busy && remaining≠0 && remaining≤WARN_SECONDS.
- blink:
  - While warn=1, toggles every BLINK_DIV cycles.
  - When warn=0, blink=0 and blink counter=0.
- hold has no effect in IDLE/DONE.

Decomposition:
- Shared package `meter_pkg`: state enum (IDLE, RUN, HOLD, DONE), default PRESCALE/SEG_SECONDS constants, and the `$clog2` width helper shared with the meter FSM.
- One natural sub-module: `tick_prescaler`.
  - Function: enable + clear → one-cycle tick every PRESCALE cycles, with freeze.
  - Reused for the blink divider (instantiated twice).

Test Plan (PRESCALE=4, SEG_SECONDS=3, WARN_SECONDS=2, BLINK_DIV=2):
- Reset release, no stimulus, 20 cycles → t=busy=warn=blink=expired=0, remaining=0.
- ct pulse cycle 0 → busy=1, remaining=3 at cycle 1; remaining=2 at cycle 5, 1 at 9; DONE with t=1 only at cycle 13, remaining=0; busy=0 and expired=1 from cycle 14.
- Same as above with hold=1 during cycles 6–15 → countdown frozen at remaining=2; t=1 at cycle 23; blink toggles every 2 cycles while warn=1, including during hold.
- ct at cycle 0, second ct at cycle 8 (coincides with tick) → remaining=3 at cycle 9, no decrement to 1; t at cycle 21; expired stays 0 throughout.
- ct at cycle 0, rst_n low asynchronously mid-cycle 6 for 2 cycles → all outputs 0 immediately; stays IDLE after release; no t ever; a new ct restarts normally with 12-cycle interval.
- ct at cycle 0, ct again exactly at DONE cycle 13 → t=1 at cycle 13, remaining=3 and busy=1 at cycle 14, expired stays 0.
